control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
// Hardwired control unit for the 32-bit cpu datapath. Fetches via PC/MAR/MDR, decodes IR, and drives
// per-cycle datapath strobes (register in/out selects, Y/Z/HI/LO enables, ALU op_code) for ALU instructions.
// Sits beside cpu at top level; its outputs connect to the datapath's *_enable and *out ports.
// PARAMETERS
// OPW  5   opcode width (IR[31:27])
// RSW  4   register-field width (ra=IR[26:23], rb=IR[22:19], rc=IR[18:15])
// CNTW 16  width of retired-instruction counter
// PORTS
// clk            in   1     rising-edge clock
// reset          in   1     synchronous, active-high
// ir             in   32    IR contents from datapath
// mem_rdy        in   1     memory has valid Mdatain this cycle
// step           in   1     single-step advance pulse (used only with CS_STEP_EN)
// PCout,MARin,pcInc,PCin,MDR_read,MDRin,MDRout,IRin,Yin  out 1 each  datapath strobes
// Zlow_enable,Zhigh_enable,Zlowout,Zhighout,HI_enable,LO_enable  out 1 each
// reg_in_sel     out  16    one-hot R0..R15 load enable
// reg_out_sel    out  16    one-hot R0..R15 bus drive
// op_code        out  OPW   ALU operation, 0 when idle
// run            out  1     1 while executing, 0 when halted
// retired        out  CNTW  completed-instruction count
// BEHAVIOUR
// - Reset (sampled on clk edge): state=T0, retired=0, run=1, every strobe/select/op_code = 0.
// - Moore outputs decoded from registered state; at most one reg_out_sel bit and one bus source per cycle.
// - T0: PCout, MARin, pcInc, Zlow_enable.
// - T1: MDR_read held; waits while mem_rdy=0 (MDRin, Zlowout, PCin low). Cycle with mem_rdy=1: MDRin,
//   Zlowout, PCin asserted once, go T2.
// - T2: MDRout, IRin. T3 decodes ir[31:27]:
//   3-reg ALU (ADD 00011,SUB 00100,AND 00101,OR 00110,SHR 00111,SHL 01001,ROR 01010,ROL 01011):
//     T3 rb out,Yin; T4 rc out,op_code,Zlow_enable; T5 Zlowout, ra in -> T0.
//   2-reg unary (NEG 10001, NOT 10010): T3 rb out,op_code,Zlow_enable; T4 Zlowout, ra in -> T0.
//   MUL 01111/DIV 10000: T3 ra out,Yin; T4 rb out,op_code,Zlow_enable,Zhigh_enable;
//     T5 Zlowout,LO_enable; T6 Zhighout,HI_enable -> T0.
//   NOP 11010 and undefined opcodes: T3 no strobes -> T0 (counted as retired).
//   HALT 11011: HALTED; run=0, all strobes 0, held until reset.
// - retired increments on the final execute cycle of each instruction; wraps 2^CNTW-1 -> 0.
// - Latency with mem_rdy=1: 3-reg 6 cycles, unary 5, MUL/DIV 7, NOP 4.
// - Reset mid-instruction aborts it: next cycle T0, outputs as reset, no partial register writes.
// CONFIGURATION
// CS_STEP_EN defined: after each final execute cycle go to PAUSE (all strobes 0, run=1); leave to T0
//   on a cycle with step=1; step ignored outside PAUSE; step held high advances one instruction per cycle.
// CS_STEP_EN undefined: no PAUSE state; step ignored; final execute cycle goes straight to T0.
// STRUCTURE
// - cs_pkg: opcode localparams, state encoding (T0..T6, PAUSE, HALTED), field bit positions.
// - Sub-module reg_sel_decode: RSW-bit index + enable -> 16-bit one-hot; two instances (in/out).
// TESTING
// 1. reset for 2 cycles -> all strobes 0, reg selects 0x0000, retired=0, run=1, T0 strobes next cycle.
// 2. ir=0x90080000 (not r0,r1), mem_rdy=1 -> T3 reg_out_sel=0x0002, op_code=10010, Zlow_enable;
//    T4 Zlowout, reg_in_sel=0x0001; retired=1 after 5 cycles.
// 3. ir=0x19890000 (add r3,r1,r2) -> T3 out 0x0002+Yin; T4 out 0x0004, op_code=00011; T5 in 0x0008.
// 4. mem_rdy low 3 cycles in T1 -> T1 held 4 cycles, MDR_read high throughout, PCin/MDRin pulse once.
// 5. MUL r4,r5 then reset asserted in T5 -> LO_enable seen once, HI_enable never, T0 follows, retired=0.
// 6. HALT opcode -> run=0 one cycle after T3, strobes 0 for 20 cycles; with CS_STEP_EN, NOP stalls
//    in PAUSE until step=1, retired advances by exactly 1 per step pulse.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Contents:
//   - default widths for the opcode, register fields and retired counter
//   - opcode values
//   - control-step state encoding
//   - instruction class decode helper
// The optional single-step feature is enabled by defining CS_STEP_EN.
// This package only holds definitions.
package cs_pkg;

   localparam int CS_OPW  = 5;
   localparam int CS_RSW  = 4;
   localparam int CS_CNTW = 16;

   // Bit position of the top of the opcode field in IR.
   // The ra, rb and rc fields follow it, packed downwards.
   localparam int IR_OP_MSB = 31;

   localparam logic [CS_OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [CS_OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [CS_OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [CS_OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [CS_OPW-1:0] OP_SHR  = 5'b00111;
   localparam logic [CS_OPW-1:0] OP_SHL  = 5'b01001;
   localparam logic [CS_OPW-1:0] OP_ROR  = 5'b01010;
   localparam logic [CS_OPW-1:0] OP_ROL  = 5'b01011;
   localparam logic [CS_OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [CS_OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [CS_OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [CS_OPW-1:0] OP_NOT  = 5'b10010;
   localparam logic [CS_OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [CS_OPW-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_PAUSE,
      ST_HALTED
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU3,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT
   } iclass_t;

   // Opcodes that are not listed here fall into CLS_NOP.
   // They still retire as a NOP would.
   function automatic iclass_t decode_class(input logic [CS_OPW-1:0] op);
      iclass_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU3;
         OP_NEG, OP_NOT:                 cls = CLS_UNARY;
         OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
         OP_HALT:                        cls = CLS_HALT;
         default:                        cls = CLS_NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Connection between the control sequencer and the cpu datapath.
// Inputs to the sequencer:
//   - ir      : IR contents
//   - mem_rdy : memory has valid Mdatain this cycle
//   - step    : single-step advance pulse (CS_STEP_EN builds only)
// Outputs from the sequencer:
//   - datapath strobes
//   - reg_in_sel and reg_out_sel one-hot selects
//   - op_code, run and the retired-instruction count
// Modports:
//   - master : the sequencer side
//   - slave  : the datapath side
interface control_sequencer_if
   import cs_pkg::*;
#(
   parameter int OPW  = CS_OPW,
   parameter int CNTW = CS_CNTW
);
   logic [31:0]     ir;
   logic            mem_rdy;
   logic            step;

   logic            PCout;
   logic            MARin;
   logic            pcInc;
   logic            PCin;
   logic            MDR_read;
   logic            MDRin;
   logic            MDRout;
   logic            IRin;
   logic            Yin;
   logic            Zlow_enable;
   logic            Zhigh_enable;
   logic            Zlowout;
   logic            Zhighout;
   logic            HI_enable;
   logic            LO_enable;
   logic [15:0]     reg_in_sel;
   logic [15:0]     reg_out_sel;
   logic [OPW-1:0]  op_code;
   logic            run;
   logic [CNTW-1:0] retired;

   modport master (
      input  ir, mem_rdy, step,
      output PCout, MARin, pcInc, PCin, MDR_read, MDRin, MDRout, IRin, Yin,
      output Zlow_enable, Zhigh_enable, Zlowout, Zhighout, HI_enable, LO_enable,
      output reg_in_sel, reg_out_sel, op_code, run, retired
   );

   modport slave (
      output ir, mem_rdy, step,
      input  PCout, MARin, pcInc, PCin, MDR_read, MDRin, MDRout, IRin, Yin,
      input  Zlow_enable, Zhigh_enable, Zlowout, Zhighout, HI_enable, LO_enable,
      input  reg_in_sel, reg_out_sel, op_code, run, retired
   );

endinterface

// File: rtl/reg_sel_decode.sv
// Turns a register index plus an enable into a 16-bit one-hot select for R0..R15.
// Ports:
//   - idx : register index, RSW bits
//   - en  : enable; when low the output is all zeros
//   - sel : one-hot select, bit n selects Rn
// Indices above 15 give all zeros.
module reg_sel_decode
   import cs_pkg::*;
#(
   parameter int RSW = CS_RSW
) (
   input  logic [RSW-1:0] idx,
   input  logic           en,
   output logic [15:0]    sel
);

   assign sel = en ? (16'd1 << idx) : 16'd0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit cpu datapath.
// It fetches an instruction through PC/MAR/MDR, decodes IR, and then drives
// the per-cycle datapath strobes for ALU, MUL/DIV, NOP and HALT instructions.
// Ports:
//   - clk   : rising-edge clock
//   - reset : synchronous, active-high
//   - bus   : control_sequencer_if.master (ir, mem_rdy, step in; strobes,
//             register selects, op_code, run and retired out)
// Optional feature: when CS_STEP_EN is defined, each instruction parks in
// PAUSE after its final execute cycle until a step pulse arrives.
//
// state   | meaning
// --------+--------------------------------------------------------------
// T0      | PC to MAR, increment PC into Z
// T1      | memory read; waits for mem_rdy, then loads MDR and new PC
// T2      | MDR to IR
// T3..T6  | execute steps, which depend on the instruction class
// PAUSE   | single-step hold (CS_STEP_EN only); leaves on step=1
// HALTED  | run=0, all strobes idle until reset
module control_sequencer
   import cs_pkg::*;
#(
   parameter int OPW  = CS_OPW,
   parameter int RSW  = CS_RSW,
   parameter int CNTW = CS_CNTW
) (
   input  logic                  clk,
   input  logic                  reset,
   control_sequencer_if.master   bus
);

   localparam int RA_MSB = IR_OP_MSB - OPW;
   localparam int RB_MSB = RA_MSB - RSW;
   localparam int RC_MSB = RB_MSB - RSW;

   state_t          state;
   state_t          state_next;
   logic            boot;
   logic            last;
   logic [CNTW-1:0] retired_q;

   logic [OPW-1:0]  opcode;
   logic [RSW-1:0]  ra;
   logic [RSW-1:0]  rb;
   logic [RSW-1:0]  rc;
   iclass_t         cls;

   logic            in_en;
   logic            out_en;
   logic [RSW-1:0]  in_idx;
   logic [RSW-1:0]  out_idx;

   assign opcode = bus.ir[IR_OP_MSB -: OPW];
   assign ra     = bus.ir[RA_MSB -: RSW];
   assign rb     = bus.ir[RB_MSB -: RSW];
   assign rc     = bus.ir[RC_MSB -: RSW];
   assign cls    = decode_class(opcode);

`ifndef CS_STEP_EN
   logic unused_step;
   assign unused_step = bus.step;
`endif

   // boot marks the cycle that follows a reset edge.
   // It keeps every strobe low in that cycle, so T0 strobes only appear
   // once reset has been released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_T0;
         boot      <= 1'b1;
         retired_q <= '0;
      end else begin
         state <= state_next;
         boot  <= 1'b0;
         if (last) begin
            retired_q <= retired_q + CNTW'(1);
         end
      end
   end

   always_comb begin
      state_next       = state;
      last             = 1'b0;
      in_en            = 1'b0;
      out_en           = 1'b0;
      in_idx           = ra;
      out_idx          = rb;
      bus.PCout        = 1'b0;
      bus.MARin        = 1'b0;
      bus.pcInc        = 1'b0;
      bus.PCin         = 1'b0;
      bus.MDR_read     = 1'b0;
      bus.MDRin        = 1'b0;
      bus.MDRout       = 1'b0;
      bus.IRin         = 1'b0;
      bus.Yin          = 1'b0;
      bus.Zlow_enable  = 1'b0;
      bus.Zhigh_enable = 1'b0;
      bus.Zlowout      = 1'b0;
      bus.Zhighout     = 1'b0;
      bus.HI_enable    = 1'b0;
      bus.LO_enable    = 1'b0;
      bus.op_code      = '0;
      bus.run          = 1'b1;

      if (boot) begin
         state_next = ST_T0;
      end else begin
         case (state)
            ST_T0: begin
               bus.PCout       = 1'b1;
               bus.MARin       = 1'b1;
               bus.pcInc       = 1'b1;
               bus.Zlow_enable = 1'b1;
               state_next      = ST_T1;
            end
            ST_T1: begin
               bus.MDR_read = 1'b1;
               if (bus.mem_rdy) begin
                  bus.MDRin   = 1'b1;
                  bus.Zlowout = 1'b1;
                  bus.PCin    = 1'b1;
                  state_next  = ST_T2;
               end
            end
            ST_T2: begin
               bus.MDRout = 1'b1;
               bus.IRin   = 1'b1;
               state_next = ST_T3;
            end
            ST_T3: begin
               case (cls)
                  CLS_ALU3: begin
                     out_en     = 1'b1;
                     bus.Yin    = 1'b1;
                     state_next = ST_T4;
                  end
                  CLS_UNARY: begin
                     out_en          = 1'b1;
                     bus.op_code     = opcode;
                     bus.Zlow_enable = 1'b1;
                     state_next      = ST_T4;
                  end
                  CLS_MULDIV: begin
                     out_en     = 1'b1;
                     out_idx    = ra;
                     bus.Yin    = 1'b1;
                     state_next = ST_T4;
                  end
                  CLS_HALT: begin
                     state_next = ST_HALTED;
                  end
                  default: begin
                     last = 1'b1;
                  end
               endcase
            end
            ST_T4: begin
               case (cls)
                  CLS_ALU3: begin
                     out_en          = 1'b1;
                     out_idx         = rc;
                     bus.op_code     = opcode;
                     bus.Zlow_enable = 1'b1;
                     state_next      = ST_T5;
                  end
                  CLS_UNARY: begin
                     bus.Zlowout = 1'b1;
                     in_en       = 1'b1;
                     last        = 1'b1;
                  end
                  CLS_MULDIV: begin
                     out_en           = 1'b1;
                     bus.op_code      = opcode;
                     bus.Zlow_enable  = 1'b1;
                     bus.Zhigh_enable = 1'b1;
                     state_next       = ST_T5;
                  end
                  default: begin
                     state_next = ST_T0;
                  end
               endcase
            end
            ST_T5: begin
               case (cls)
                  CLS_ALU3: begin
                     bus.Zlowout = 1'b1;
                     in_en       = 1'b1;
                     last        = 1'b1;
                  end
                  CLS_MULDIV: begin
                     bus.Zlowout   = 1'b1;
                     bus.LO_enable = 1'b1;
                     state_next    = ST_T6;
                  end
                  default: begin
                     state_next = ST_T0;
                  end
               endcase
            end
            ST_T6: begin
               bus.Zhighout  = 1'b1;
               bus.HI_enable = 1'b1;
               last          = 1'b1;
            end
            ST_PAUSE: begin
`ifdef CS_STEP_EN
               if (bus.step) begin
                  state_next = ST_T0;
               end
`else
               state_next = ST_T0;
`endif
            end
            ST_HALTED: begin
               bus.run = 1'b0;
            end
            default: begin
               state_next = ST_T0;
            end
         endcase
      end

      if (last) begin
`ifdef CS_STEP_EN
         state_next = ST_PAUSE;
`else
         state_next = ST_T0;
`endif
      end
   end

   assign bus.retired = retired_q;

   reg_sel_decode #(.RSW(RSW)) u_in_sel (
      .idx (in_idx),
      .en  (in_en),
      .sel (bus.reg_in_sel)
   );

   reg_sel_decode #(.RSW(RSW)) u_out_sel (
      .idx (out_idx),
      .en  (out_en),
      .sel (bus.reg_out_sel)
   );

endmodule
